// File: rtl/sub8_pkg.sv
// Shared types and helpers for the subtractor pipeline and the prefix adder.
package sub8_pkg;

  localparam int WIDTH = 8;

  // Generate/propagate pair for one bit or one prefix group.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Merge a higher group (hi) with the adjacent lower group (lo).
  function automatic gp_t prefix_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/sub8_pipe_prefix_carry.sv
// Kogge-Stone carry tree: c_o[i] is the carry into bit i, c_o[N] the carry out.
module prefix_carry
  import sub8_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] p_i,
  input  logic         cin_i,
  output logic [N:0]   c_o
);

  gp_t cur [N];
  gp_t nxt [N];

  // Fold cin into bit 0, then log2(N) levels of prefix combining.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cur[i].g = g_i[i];
      cur[i].p = p_i[i];
    end
    cur[0].g = g_i[0] | (p_i[0] & cin_i);
    nxt = cur;
    for (int d = 1; d < N; d = d * 2) begin
      nxt = cur;
      for (int i = 0; i < N; i++) begin
        if (i >= d) nxt[i] = prefix_combine(cur[i], cur[i-d]);
      end
      cur = nxt;
    end
    c_o[0] = cin_i;
    for (int i = 0; i < N; i++) c_o[i+1] = cur[i].g;
  end

endmodule

// File: rtl/sub8_pipe.sv
// Two-stage pipelined subtractor (a + ~b + 1) with borrow and signed overflow.
// The carry chain is cut at SPLIT: low half resolved in stage 1, high half in stage 2.
module sub8_pipe
  import sub8_pkg::*;
#(
  parameter int WIDTH = sub8_pkg::WIDTH,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int HI = WIDTH - SPLIT;

  logic [WIDTH-1:0] p_in, g_in;
  logic [SPLIT:0]   c_lo;
  logic [HI:0]      c_hi;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q;
  logic [HI-1:0]    s1_g_hi_q;
  logic [SPLIT-1:0] s1_diff_lo_q;
  logic             s1_c_split_q, s1_a_msb_q, s1_b_msb_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;

  logic             accept, s2_load;

  assign p_in = a_in ^ ~b_in;
  assign g_in = a_in & ~b_in;

  prefix_carry #(.N(SPLIT)) u_lo (
    .g_i   (g_in[SPLIT-1:0]),
    .p_i   (p_in[SPLIT-1:0]),
    .cin_i (1'b1),
    .c_o   (c_lo)
  );

  prefix_carry #(.N(HI)) u_hi (
    .g_i   (s1_g_hi_q),
    .p_i   (s1_p_q[WIDTH-1:SPLIT]),
    .cin_i (s1_c_split_q),
    .c_o   (c_hi)
  );

  // Handshake: s2 drains when empty or downstream ready; the same move frees s1.
  always_comb begin
    s2_load    = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready   = ~s1_valid_q | ~s2_valid_q | out_ready;
    accept     = in_valid & in_ready;
    s1_valid_d = accept | (s1_valid_q & ~s2_load);
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
  end

  // Stage-2 result: high half from the second carry tree, flags from the carry out.
  always_comb begin
    diff_d   = {s1_p_q[WIDTH-1:SPLIT] ^ c_hi[HI-1:0], s1_diff_lo_q};
    borrow_d = ~c_hi[HI];
    ovf_d    = (s1_a_msb_q ^ s1_b_msb_q) & (diff_d[WIDTH-1] ^ s1_a_msb_q);
  end

  // Stage 1: capture propagate/generate, low-half result and the split carry.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_p_q       <= '0;
      s1_g_hi_q    <= '0;
      s1_diff_lo_q <= '0;
      s1_c_split_q <= 1'b0;
      s1_a_msb_q   <= 1'b0;
      s1_b_msb_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_p_q       <= p_in;
        s1_g_hi_q    <= g_in[WIDTH-1:SPLIT];
        s1_diff_lo_q <= p_in[SPLIT-1:0] ^ c_lo[SPLIT-1:0];
        s1_c_split_q <= c_lo[SPLIT];
        s1_a_msb_q   <= a_in[WIDTH-1];
        s1_b_msb_q   <= b_in[WIDTH-1];
      end
    end
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_sub8_pipe.sv
// Directed and swept checks for the two-stage subtractor.
module tb_sub8_pipe;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [7:0] a_in, b_in, diff;
  logic       in_valid, in_ready, borrow_out, ovf_out, out_valid, out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  sub8_pipe dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .a_in       (a_in),
    .b_in       (b_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf_out    (ovf_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    #2;
    n_cmp++;
    if ({out_valid, diff, borrow_out, ovf_out} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%b o=%b, want all 0",
               out_valid, diff, borrow_out, ovf_out);
    end
    tick(); tick();
    wb_rst_i = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // One operation on an empty pipe: result appears two edges after accept, for one cycle.
  task automatic test_arith(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                            input logic eb, input logic eo, input string nm);
    in_valid = 1'b1; a_in = a; b_in = b; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_in_ready: got %b want 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_early_valid: got %b want 0", nm, out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, diff, borrow_out, ovf_out} !== {1'b1, ed, eb, eo}) begin
      n_fail++;
      $display("FAIL %s_result: got v=%b d=%h b=%b o=%b, want v=1 d=%h b=%b o=%b",
               nm, out_valid, diff, borrow_out, ovf_out, ed, eb, eo);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_valid_width: got %b want 0", nm, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] bv [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] ev [4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
    logic [7:0] got [$];
    int idx = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid  = (idx < 4);
      a_in      = (idx < 4) ? av[idx] : 8'h00;
      b_in      = (idx < 4) ? bv[idx] : 8'h00;
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        n_cmp++;
        if ({in_ready, out_valid, diff} !== {1'b0, 1'b1, 8'h0F}) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got rdy=%b v=%b d=%h, want rdy=0 v=1 d=0f",
                   cyc, in_ready, out_valid, diff);
        end
      end
      if (out_valid && out_ready) got.push_back(diff);
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got.size() != 4 || idx != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d out / %0d in, want 4 / 4", got.size(), idx);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev[i]) begin
        n_fail++; $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], ev[i]);
      end
    end
    tick();
  endtask

  // Every a against 64 spread b values, with random backpressure and a scoreboard.
  task automatic test_sweep();
    logic [9:0] exp_q [$];
    logic [9:0] e;
    int n_in = 0;
    int total = 256 * 64;
    int cyc = 0;
    int ia, ib, sa, sb, dv, dsg;
    while ((n_in < total || exp_q.size() != 0) && cyc < 40000) begin
      ia = n_in / 64;
      ib = ((n_in % 64) * 4 + ia) % 256;
      in_valid  = (n_in < total);
      a_in      = 8'(ia);
      b_in      = 8'(ib);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra: got d=%h with nothing expected", diff);
        end else begin
          e = exp_q.pop_front();
          if ({diff, borrow_out, ovf_out} !== e) begin
            n_fail++;
            $display("FAIL sweep: got d=%h b=%b o=%b, want d=%h b=%b o=%b",
                     diff, borrow_out, ovf_out, e[9:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        dv  = (ia - ib) & 8'hFF;
        sa  = (ia >> 7) & 1;
        sb  = (ib >> 7) & 1;
        dsg = (dv >> 7) & 1;
        exp_q.push_back({8'(dv), (ia < ib), ((sa != sb) && (dsg != sa))});
        n_in++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_in != total || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_timeout: got %0d in / %0d pending, want %0d / 0",
               n_in, exp_q.size(), total);
    end
    out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; a_in = 8'h44; b_in = 8'h11;
    tick();
    a_in = 8'h66; b_in = 8'h22;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_full: got v=%b rdy=%b, want v=1 rdy=0", out_valid, in_ready);
    end
    wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, diff} !== 9'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b d=%h, want v=0 d=00", out_valid, diff);
    end
    tick();
    wb_rst_i = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_stale[%0d]: got v=%b d=%h want v=0", i, out_valid, diff);
      end
    end
    test_arith(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    tick();
    test_arith(8'h50, 8'h30, 8'h20, 1'b0, 1'b0, "sub_50_30");
    test_arith(8'h30, 8'h50, 8'hE0, 1'b1, 1'b0, "sub_30_50");
    test_arith(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    test_arith(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub_7f_ff");
    test_arith(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "sub_00_00");
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
